sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word address width toward the SDRAM controller.
REQ-002 SHALL have parameter DATA_W, default 16, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter TAG_DEPTH, default 8, maximum outstanding reads (power of two).
REQ-004 SHALL have port clk_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have, for each master port p = 0 and 1, these ports: mp_address in ADDR_W; mp_read in 1; mp_write in 1; mp_writedata in DATA_W; mp_byteenable in DATA_W/8; mp_waitrequest out 1; mp_readdata out DATA_W; mp_readdatavalid out 1.
REQ-007 SHALL have these controller-side ports: s_address out ADDR_W; s_read out 1; s_write out 1; s_writedata out DATA_W; s_byteenable out DATA_W/8; s_waitrequest in 1; s_readdata in DATA_W; s_readdatavalid in 1.
REQ-008 SHALL have port err_orphan, output, 1, a sticky flag for readdatavalid received with no outstanding read.

Function
REQ-009 SHALL treat a master as requesting when its mp_read or mp_write is high; read and write high together SHALL be treated as a read.
REQ-010 SHALL choose at most one master per cycle by round-robin.
  - Pointer rr_last holds the master most recently accepted.
  - The other master wins when both request.
REQ-011 SHALL drive the winner's command combinationally onto the s_* command ports in the same cycle, and SHALL hold s_read and s_write low when no master wins.
REQ-012 SHALL accept a command when s_waitrequest is low and the command is not blocked (see REQ-016).
  - On acceptance, the winner's mp_waitrequest SHALL be low for that cycle.
  - Every other mp_waitrequest SHALL be high.
REQ-013 SHALL update rr_last only on acceptance; a stalled winner SHALL keep the grant until it is accepted or withdraws its request.
REQ-014 SHALL push the winning master's ID into a TAG_DEPTH-entry tag FIFO on each accepted read.
REQ-015 SHALL, on s_readdatavalid, pop the FIFO and drive that master's mp_readdata and mp_readdatavalid exactly 1 cycle later, with the other master's mp_readdatavalid low.
REQ-016 SHALL block reads while the FIFO is full; writes SHALL still be accepted while the FIFO is full.
REQ-017 SHALL allow a push and a pop in the same cycle, leaving the occupancy unchanged, including when the FIFO is full.
REQ-018 SHALL ignore s_readdatavalid while the FIFO is empty and SHALL set err_orphan, which stays set until reset.
REQ-019 SHALL wrap the FIFO read and write pointers modulo TAG_DEPTH and track occupancy in a counter 0..TAG_DEPTH.
REQ-020 SHALL allow mp_readdata to hold any value while mp_readdatavalid is low.

Reset
REQ-021 SHALL, while reset_reset is high, drive:
  - mp_waitrequest = 1;
  - s_read, s_write and mp_readdatavalid = 0;
  - err_orphan = 0.
REQ-022 SHALL, on reset, clear the FIFO and set rr_last = 1, so master 0 wins first.
REQ-023 SHALL discard reads outstanding when reset is asserted mid-operation; data returned after reset is released SHALL count as orphan (REQ-018).

Configuration
REQ-024 SHALL support compile macro SDRAM_ARB_PERF_EN.
  - Defined: adds outputs perf_acc0 and perf_acc1 (32-bit each, count of commands accepted per master) and perf_stall (32-bit, count of cycles in which some master requested and none was accepted).
  - All three counters SHALL reset to 0 and wrap at 2^32.
REQ-025 SHALL, without SDRAM_ARB_PERF_EN, omit those ports and counters entirely, with the arbitration function unchanged.

Structure
REQ-026 SHALL place in a shared package sdram_arb_pkg:
  - the master-ID type (1 bit);
  - constant NUM_MASTERS = 2;
  - default constants for ADDR_W, DATA_W and TAG_DEPTH.
REQ-027 SHALL implement the tag FIFO as sub-module sdram_arb_tag_fifo, with push, pop, din, dout, full, empty and count ports.

Verification
REQ-028 SHALL cover alternating round-robin: m0 and m1 both write continuously with s_waitrequest=0 -> accepted order is m0, m1, m0, m1; each master's waitrequest is low on alternate cycles.
REQ-029 SHALL cover read routing: m0 reads 0x0000010, m1 reads 0x1000020, then s_readdatavalid on 2 cycles with 0xAAAA then 0x5555 -> m0 gets 0xAAAA, m1 gets 0x5555, each 1 cycle after the slave pulse.
REQ-030 SHALL cover a full FIFO: 8 reads from m0 with no readdatavalid -> 9th read stalled; m1 write accepted; one s_readdatavalid -> the stalled read is accepted in that same cycle.
REQ-031 SHALL cover a controller stall: s_waitrequest=1 for 5 cycles while m1 is granted and m0 starts requesting -> grant stays on m1 with s_* stable; m1 is accepted on release, then m0.
REQ-032 SHALL cover orphan data and reset mid-operation:
  - s_readdatavalid with FIFO empty -> err_orphan=1.
  - Reset with 3 reads outstanding -> after reset, FIFO empty, err_orphan=0, master 0 wins first.
REQ-033 SHALL cover performance counters under SDRAM_ARB_PERF_EN: 10 accepted m0 commands and 4 stall cycles -> perf_acc0=10, perf_acc1=0, perf_stall=4.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-master SDRAM port arbiter.
//   master_id_t      : identifies master 0 or master 1
//   NUM_MASTERS      : number of arbitrated master ports
//   *_DEFAULT        : default parameter values for the arbiter
package sdram_arb_pkg;

  typedef logic master_id_t;

  localparam int unsigned NUM_MASTERS       = 2;
  localparam int unsigned ADDR_W_DEFAULT    = 25;
  localparam int unsigned DATA_W_DEFAULT    = 16;
  localparam int unsigned TAG_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO recording which master owns each outstanding read.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push, din      : write din when not full (or when popping in the same cycle)
//   pop, dout      : dout is the head entry; pop removes it when not empty
//   full, empty    : occupancy flags
//   count          : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sdram_arb_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [CntW-1:0] CntOne = 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of an Avalon-style SDRAM controller.
// Ports:
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   mp0_* / mp1_*             : master command ports with waitrequest and read return
//   s_*                       : single command/return port toward the controller
//   err_orphan                : sticky, set by read data arriving with no read outstanding
//   perf_acc0/1, perf_stall   : only with SDRAM_ARB_PERF_EN defined; accepted commands per
//                               master and cycles with a request but no acceptance
// Read returns are routed in order through a tag FIFO and appear one cycle after
// s_readdatavalid.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   mp0_address,
  input  logic                mp0_read,
  input  logic                mp0_write,
  input  logic [DATA_W-1:0]   mp0_writedata,
  input  logic [DATA_W/8-1:0] mp0_byteenable,
  output logic                mp0_waitrequest,
  output logic [DATA_W-1:0]   mp0_readdata,
  output logic                mp0_readdatavalid,
  input  logic [ADDR_W-1:0]   mp1_address,
  input  logic                mp1_read,
  input  logic                mp1_write,
  input  logic [DATA_W-1:0]   mp1_writedata,
  input  logic [DATA_W/8-1:0] mp1_byteenable,
  output logic                mp1_waitrequest,
  output logic [DATA_W-1:0]   mp1_readdata,
  output logic                mp1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
`ifdef SDRAM_ARB_PERF_EN
  output logic [31:0]         perf_acc0,
  output logic [31:0]         perf_acc1,
  output logic [31:0]         perf_stall,
`endif
  output logic                err_orphan
);

  localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

  logic [NUM_MASTERS-1:0] req, rd, elig;
  master_id_t             win, rr_last_q, lock_id_q;
  logic                   win_valid, win_read, accept, lock_q;
  logic                   read_blocked;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  master_id_t             fifo_dout;
  logic [CntW-1:0]        fifo_count;
  logic                   rdv_q, err_q;
  master_id_t             rid_q;
  logic [DATA_W-1:0]      rdata_q;

  always_comb begin
    req      = {mp1_read | mp1_write, mp0_read | mp0_write};
    rd       = {mp1_read, mp0_read};
    fifo_pop = s_readdatavalid && !fifo_empty && !reset_reset;
    // A full FIFO still takes a read if the head is retired in the same cycle.
    read_blocked = fifo_full && !fifo_pop;
    elig         = req & ~(rd & {NUM_MASTERS{read_blocked}});

    win       = 1'b0;
    win_valid = 1'b0;
    if (lock_q && elig[lock_id_q]) begin
      // Keep the grant on a master stalled by the controller.
      win       = lock_id_q;
      win_valid = 1'b1;
    end else if (elig == 2'b11) begin
      win       = ~rr_last_q;
      win_valid = 1'b1;
    end else if (elig[0]) begin
      win       = 1'b0;
      win_valid = 1'b1;
    end else if (elig[1]) begin
      win       = 1'b1;
      win_valid = 1'b1;
    end
    if (reset_reset) win_valid = 1'b0;

    win_read  = rd[win];
    accept    = win_valid && !s_waitrequest;
    fifo_push = accept && win_read;

    s_address    = win ? mp1_address    : mp0_address;
    s_writedata  = win ? mp1_writedata  : mp0_writedata;
    s_byteenable = win ? mp1_byteenable : mp0_byteenable;
    s_read       = win_valid && win_read;
    s_write      = win_valid && !win_read;

    mp0_waitrequest = !(accept && (win == 1'b0));
    mp1_waitrequest = !(accept && (win == 1'b1));
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rr_last_q <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (accept) rr_last_q <= win;
      lock_q    <= win_valid && !accept;
      lock_id_q <= win;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     ($bits(master_id_t))
  ) u_tag_fifo (
    .clk   (clk_clk),
    .reset (reset_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (win),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read return: register data and owner so the master sees it one cycle later.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rdv_q <= 1'b0;
      rid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdv_q <= fifo_pop;
      if (fifo_pop) rid_q <= fifo_dout;
      if (s_readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (fifo_pop) rdata_q <= s_readdata;
  end

  assign mp0_readdata      = rdata_q;
  assign mp1_readdata      = rdata_q;
  assign mp0_readdatavalid = rdv_q && (rid_q == 1'b0) && !reset_reset;
  assign mp1_readdatavalid = rdv_q && (rid_q == 1'b1) && !reset_reset;
  assign err_orphan        = err_q && !reset_reset;

`ifdef SDRAM_ARB_PERF_EN
  logic [31:0] acc0_q, acc1_q, stall_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      acc0_q  <= '0;
      acc1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (accept && (win == 1'b0)) acc0_q <= acc0_q + 32'd1;
      if (accept && (win == 1'b1)) acc1_q <= acc1_q + 32'd1;
      if ((|req) && !accept)       stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_acc0  = acc0_q;
  assign perf_acc1  = acc1_q;
  assign perf_stall = stall_q;
`endif

  // Occupancy can never exceed the FIFO size.
  count_in_range: assert property (@(posedge clk_clk) disable iff (reset_reset)
    fifo_count <= CntW'(TAG_DEPTH));

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: reset state, round-robin, read routing,
// full tag FIFO, controller stall with grant hold, orphan data, mid-operation reset
// and (with SDRAM_ARB_PERF_EN) the performance counters.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mp0_address, mp1_address, s_address;
  logic          mp0_read, mp0_write, mp1_read, mp1_write;
  logic [DW-1:0] mp0_writedata, mp1_writedata, s_writedata;
  logic [1:0]    mp0_byteenable, mp1_byteenable, s_byteenable;
  logic          mp0_waitrequest, mp1_waitrequest;
  logic [DW-1:0] mp0_readdata, mp1_readdata, s_readdata;
  logic          mp0_readdatavalid, mp1_readdatavalid;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid;
  logic          err_orphan;
`ifdef SDRAM_ARB_PERF_EN
  logic [31:0]   perf_acc0, perf_acc1, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TAG_DEPTH (8)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .mp0_address       (mp0_address),
    .mp0_read          (mp0_read),
    .mp0_write         (mp0_write),
    .mp0_writedata     (mp0_writedata),
    .mp0_byteenable    (mp0_byteenable),
    .mp0_waitrequest   (mp0_waitrequest),
    .mp0_readdata      (mp0_readdata),
    .mp0_readdatavalid (mp0_readdatavalid),
    .mp1_address       (mp1_address),
    .mp1_read          (mp1_read),
    .mp1_write         (mp1_write),
    .mp1_writedata     (mp1_writedata),
    .mp1_byteenable    (mp1_byteenable),
    .mp1_waitrequest   (mp1_waitrequest),
    .mp1_readdata      (mp1_readdata),
    .mp1_readdatavalid (mp1_readdatavalid),
    .s_address         (s_address),
    .s_read            (s_read),
    .s_write           (s_write),
    .s_writedata       (s_writedata),
    .s_byteenable      (s_byteenable),
    .s_waitrequest     (s_waitrequest),
    .s_readdata        (s_readdata),
    .s_readdatavalid   (s_readdatavalid),
`ifdef SDRAM_ARB_PERF_EN
    .perf_acc0         (perf_acc0),
    .perf_acc1         (perf_acc1),
    .perf_stall        (perf_stall),
`endif
    .err_orphan        (err_orphan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    mp0_address = '0; mp0_read = 0; mp0_write = 0; mp0_writedata = '0; mp0_byteenable = 2'b11;
    mp1_address = '0; mp1_read = 0; mp1_write = 0; mp1_writedata = '0; mp1_byteenable = 2'b11;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();

    // Reset state, with a master already requesting
    mp0_write = 1'b1;
    mid();
    check("rst_wait0",  32'(mp0_waitrequest), 1);
    check("rst_wait1",  32'(mp1_waitrequest), 1);
    check("rst_s_write", 32'(s_write), 0);
    check("rst_s_read", 32'(s_read), 0);
    check("rst_rdv0",   32'(mp0_readdatavalid), 0);
    check("rst_err",    32'(err_orphan), 0);
    step();
    rst = 1'b0;
    idle();

    // Alternating round-robin, both masters writing continuously
    mp0_write = 1; mp0_address = 25'h100; mp0_writedata = 16'h1111;
    mp1_write = 1; mp1_address = 25'h200; mp1_writedata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("rr%0d_s_write", i), 32'(s_write), 1);
      check($sformatf("rr%0d_addr", i), 32'(s_address), (i % 2) ? 32'h200 : 32'h100);
      check($sformatf("rr%0d_wdata", i), 32'(s_writedata), (i % 2) ? 32'h2222 : 32'h1111);
      check($sformatf("rr%0d_wait0", i), 32'(mp0_waitrequest), (i % 2) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_wait1", i), 32'(mp1_waitrequest), (i % 2) ? 32'd0 : 32'd1);
      step();
    end
    idle();

    // Read routing through the tag FIFO
    mp0_read = 1; mp0_address = 25'h0000010;
    mid();
    check("rd_m0_wait", 32'(mp0_waitrequest), 0);
    check("rd_m0_s_read", 32'(s_read), 1);
    check("rd_m0_addr", 32'(s_address), 32'h10);
    step();
    idle();
    mp1_read = 1; mp1_address = 25'h1000020;
    mid();
    check("rd_m1_wait", 32'(mp1_waitrequest), 0);
    check("rd_m1_addr", 32'(s_address), 32'h1000020);
    step();
    idle();
    s_readdatavalid = 1; s_readdata = 16'hAAAA;
    mid();
    check("rd_early_rdv0", 32'(mp0_readdatavalid), 0);
    step();
    s_readdata = 16'h5555;
    mid();
    check("rd_ret0_rdv0", 32'(mp0_readdatavalid), 1);
    check("rd_ret0_data", 32'(mp0_readdata), 32'hAAAA);
    check("rd_ret0_rdv1", 32'(mp1_readdatavalid), 0);
    step();
    s_readdatavalid = 0;
    mid();
    check("rd_ret1_rdv1", 32'(mp1_readdatavalid), 1);
    check("rd_ret1_data", 32'(mp1_readdata), 32'h5555);
    check("rd_ret1_rdv0", 32'(mp0_readdatavalid), 0);
    step();

    // Full FIFO: 8 reads accepted, 9th blocked, writes still pass
    mp0_read = 1;
    for (int i = 0; i < 8; i++) begin
      mp0_address = 25'(32'h40 + i);
      mid();
      check($sformatf("fill%0d_wait0", i), 32'(mp0_waitrequest), 0);
      step();
    end
    mid();
    check("full_wait0", 32'(mp0_waitrequest), 1);
    check("full_s_read", 32'(s_read), 0);
    step();
    mp1_write = 1; mp1_address = 25'h300;
    mid();
    check("full_wr_wait1", 32'(mp1_waitrequest), 0);
    check("full_wr_s_write", 32'(s_write), 1);
    check("full_wr_wait0", 32'(mp0_waitrequest), 1);
    step();
    mp1_write = 0; s_readdatavalid = 1; s_readdata = 16'h1234;
    mid();
    check("full_pop_wait0", 32'(mp0_waitrequest), 0);
    check("full_pop_s_read", 32'(s_read), 1);
    step();
    idle();
    mid();
    check("full_pop_rdv0", 32'(mp0_readdatavalid), 1);
    check("full_pop_data", 32'(mp0_readdata), 32'h1234);
    step();

    // Drain all 8 entries; the 9th pulse finds the FIFO empty
    s_readdatavalid = 1;
    for (int i = 0; i < 9; i++) begin
      s_readdata = 16'(32'h20 + i);
      mid();
      if (i > 0) begin
        check($sformatf("drain%0d_rdv0", i), 32'(mp0_readdatavalid), 1);
        check($sformatf("drain%0d_data", i), 32'(mp0_readdata), 32'h20 + 32'(i) - 1);
      end
      check($sformatf("drain%0d_err", i), 32'(err_orphan), 0);
      step();
    end
    s_readdatavalid = 0;
    mid();
    check("orphan_err", 32'(err_orphan), 1);
    check("orphan_rdv0", 32'(mp0_readdatavalid), 0);
    check("orphan_rdv1", 32'(mp1_readdatavalid), 0);
    step();

    // Make master 1 the most recently accepted so round-robin alone would favour m0
    mp1_write = 1; mp1_address = 25'h0;
    mid();
    check("pre_stall_wait1", 32'(mp1_waitrequest), 0);
    step();

    // Controller stall: grant stays on m1 while m0 joins
    s_waitrequest = 1; mp1_address = 25'h300; mp1_writedata = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        mp0_write = 1; mp0_address = 25'h400; mp0_writedata = 16'hC0DE;
      end
      mid();
      check($sformatf("stall%0d_addr", i), 32'(s_address), 32'h300);
      check($sformatf("stall%0d_wdata", i), 32'(s_writedata), 32'hBEEF);
      check($sformatf("stall%0d_s_write", i), 32'(s_write), 1);
      check($sformatf("stall%0d_wait0", i), 32'(mp0_waitrequest), 1);
      check($sformatf("stall%0d_wait1", i), 32'(mp1_waitrequest), 1);
      step();
    end
    s_waitrequest = 0;
    mid();
    check("release_wait1", 32'(mp1_waitrequest), 0);
    check("release_addr", 32'(s_address), 32'h300);
    check("release_wait0", 32'(mp0_waitrequest), 1);
    step();
    mp1_write = 0;
    mid();
    check("after_wait0", 32'(mp0_waitrequest), 0);
    check("after_addr", 32'(s_address), 32'h400);
    step();
    idle();

    // Reset with 3 reads outstanding (err_orphan is still set from above)
    mp0_read = 1;
    for (int i = 0; i < 3; i++) begin
      mp0_address = 25'(32'h80 + i);
      mid();
      check($sformatf("pre_rst%0d_wait0", i), 32'(mp0_waitrequest), 0);
      step();
    end
    idle();
    rst = 1;
    mid();
    check("midrst_err", 32'(err_orphan), 0);
    check("midrst_wait0", 32'(mp0_waitrequest), 1);
    step();
    rst = 0;
    mp0_write = 1; mp0_address = 25'h500;
    mp1_write = 1; mp1_address = 25'h600;
    mid();
    check("postrst_err", 32'(err_orphan), 0);
    check("postrst_addr", 32'(s_address), 32'h500);
    check("postrst_wait0", 32'(mp0_waitrequest), 0);
    check("postrst_wait1", 32'(mp1_waitrequest), 1);
    step();
    idle();
    s_readdatavalid = 1; s_readdata = 16'h7777;
    step();
    s_readdatavalid = 0;
    mid();
    check("postrst_orphan_err", 32'(err_orphan), 1);
    check("postrst_orphan_rdv0", 32'(mp0_readdatavalid), 0);
    check("postrst_orphan_rdv1", 32'(mp1_readdatavalid), 0);
    step();

`ifdef SDRAM_ARB_PERF_EN
    // 4 stalled cycles then 10 accepted m0 writes
    rst = 1;
    step();
    rst = 0;
    mp0_write = 1; s_waitrequest = 1;
    repeat (4) step();
    s_waitrequest = 0;
    repeat (10) step();
    idle();
    mid();
    check("perf_acc0", perf_acc0, 10);
    check("perf_acc1", perf_acc1, 0);
    check("perf_stall", perf_stall, 4);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
